// File: rtl/blink_pkg.sv
// Shared types and helpers for the anode blink controller.
package blink_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONT  = 2'd1,
        BURST = 2'd2
    } blink_state_e;

    localparam int MAX_DIGITS = 32;

    // Blank anode vector for a display of n digits at the given polarity.
    function automatic logic [MAX_DIGITS-1:0] inactive_level(input logic active_low, input int n);
        logic [MAX_DIGITS-1:0] v;
        v = '0;
        for (int i = 0; i < MAX_DIGITS; i++) begin
            if (i < n) v[i] = active_low;
        end
        return v;
    endfunction

endpackage

// File: rtl/blink_prescaler.sv
// Half-period prescaler: counts while run is high, ticks at the end of each blink phase.
// Latency: tick is combinational from cnt and half_period. Backpressure: none.
// A shortened half_period ends the current phase immediately thanks to the >= compare.
module blink_prescaler #(
    parameter int PRESCALE_W = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  run,
    input  logic [PRESCALE_W-1:0] half_period,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] cnt;
    logic [PRESCALE_W-1:0] last_cnt;

    always_comb begin
        last_cnt = (half_period == '0) ? '0 : half_period - PRESCALE_W'(1);
    end

    assign tick = run && (cnt >= last_cnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!run || tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + PRESCALE_W'(1);
        end
    end

endmodule

// File: rtl/digit_blink_ctrl.sv
// Anode blink controller: blanks masked digits in continuous or counted-burst mode.
// Latency: anode_out is anode_in registered, 1 cycle. Backpressure: none, inputs sampled every cycle.
// start is a single-cycle pulse; done pulses one cycle when a burst completes.
module digit_blink_ctrl
    import blink_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int PRESCALE_W = 24,
    parameter int BURST_W    = 4,
    parameter bit ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_DIGITS-1:0] anode_in,
    input  logic                  blink_en,
    input  logic [NUM_DIGITS-1:0] blink_mask,
    input  logic [PRESCALE_W-1:0] half_period,
    input  logic                  burst_mode,
    input  logic [BURST_W-1:0]    burst_count,
    input  logic                  start,
    output logic [NUM_DIGITS-1:0] anode_out,
    output logic                  phase,
    output logic                  busy,
    output logic                  done
);

    localparam logic [MAX_DIGITS-1:0] BLANK_ALL = inactive_level(ACTIVE_LOW, NUM_DIGITS);
    localparam logic [NUM_DIGITS-1:0] BLANK     = BLANK_ALL[NUM_DIGITS-1:0];

    blink_state_e         state, state_nxt;
    logic                 phase_nxt, done_nxt;
    logic [BURST_W-1:0]   pairs, pairs_nxt;
    logic [BURST_W-1:0]   burst_lat, burst_lat_nxt;
    logic                 run, tick, burst_last;

    assign run = (state != IDLE);

    blink_prescaler #(.PRESCALE_W(PRESCALE_W)) u_prescaler (
        .clk         (clk),
        .rst_n       (rst_n),
        .run         (run),
        .half_period (half_period),
        .tick        (tick)
    );

    // The final visible phase of the latched pair count ends the burst.
    assign burst_last = tick && phase && (pairs == burst_lat - BURST_W'(1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            busy      <= 1'b0;
            phase     <= 1'b1;
            done      <= 1'b0;
            pairs     <= '0;
            burst_lat <= '0;
            anode_out <= BLANK;
        end else begin
            state     <= state_nxt;
            busy      <= (state_nxt != IDLE);
            phase     <= phase_nxt;
            done      <= done_nxt;
            pairs     <= pairs_nxt;
            burst_lat <= burst_lat_nxt;
            anode_out <= (run && !phase) ? ((anode_in & ~blink_mask) | (BLANK & blink_mask))
                                         : anode_in;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && burst_mode) begin
                    if (burst_count != '0) state_nxt = BURST;
                end else if (blink_en && !burst_mode) begin
                    state_nxt = CONT;
                end
            end
            CONT:    if (!blink_en || burst_mode) state_nxt = IDLE;
            BURST:   if (burst_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        phase_nxt     = phase;
        pairs_nxt     = pairs;
        burst_lat_nxt = burst_lat;
        done_nxt      = ((state == IDLE) && start && burst_mode && (burst_count == '0)) ||
                        ((state == BURST) && burst_last);
        if (state_nxt == IDLE) begin
            phase_nxt = 1'b1;
            pairs_nxt = '0;
        end else if (state == IDLE) begin
            // Blank phase first so an edit is visible immediately.
            phase_nxt     = 1'b0;
            pairs_nxt     = '0;
            burst_lat_nxt = burst_count;
        end else if (tick) begin
            phase_nxt = !phase;
            if ((state == BURST) && phase) pairs_nxt = pairs + BURST_W'(1);
        end
    end

endmodule
